spi_word_initiator: RTL

//  Host-side SPI initiator for the 64-bit word protocol terminated by the on-chip SPI word target.

---
 rtl/spi_word_initiator_pkg.sv | 25 ++
 rtl/spi_sck_divider.sv | 37 +++
 rtl/spi_word_initiator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_word_initiator_pkg.sv
// Shared definitions for the SPI word initiator: FSM states, the default word
// width and the counter sizing helper.
package spi_word_initiator_pkg;

  localparam int SPI_WORD_BITS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Wide enough for the largest phase length, with one spare bit so no counter can wrap.
  function automatic int count_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/spi_sck_divider.sv
// SCK generator: while run is high, SCK spends CLK_DIV cycles low then CLK_DIV
// cycles high; rise/fall strobe on the cycle whose closing edge moves SCK.
module spi_sck_divider #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 3
) (
  input  logic CLK,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  logic [CNT_W-1:0] half_cnt;
  logic             phase_end;

  assign phase_end = run && (half_cnt == CNT_W'(CLK_DIV - 1));
  assign sck_rise  = phase_end && !sck;
  assign sck_fall  = phase_end && sck;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (!run) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (phase_end) begin
      half_cnt <= '0;
      sck      <= ~sck;
    end else begin
      half_cnt <= half_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_word_initiator.sv
// Host-side SPI mode-0 initiator: frames one word per handshake under CS,
// sending byte 0 first with each byte MSB first, and captures the CIPO reply.
module spi_word_initiator
  import spi_word_initiator_pkg::*;
#(
  parameter int WORD_BITS = SPI_WORD_BITS,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_GAP    = 4
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 halt,
  output logic [WORD_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 SCK,
  output logic                 CS,
  output logic                 COPI,
  input  logic                 CIPO
);

  localparam int CNT_W  = count_width(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
  localparam int BIT_W  = $clog2(WORD_BITS) + 1;
  localparam int NBYTES = WORD_BITS / 8;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] tx_shift, rx_shift, tx_swapped, rx_swapped;
  logic                 sck_level, sck_rise, sck_fall, div_run;
  logic                 accept, abort, last_bit, hold_done;

  assign accept    = (state == ST_IDLE) && tx_valid && tx_ready;
  assign abort     = halt && (state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
  assign last_bit  = (bit_cnt == BIT_W'(WORD_BITS - 1));
  assign hold_done = (cnt == CNT_W'(CS_HOLD - 1));
  assign div_run   = (state == ST_SHIFT) && !halt;
  assign busy      = (state != ST_IDLE);
  assign SCK       = sck_level && !abort;

  spi_sck_divider #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_sck_divider (
    .CLK     (CLK),
    .reset   (reset),
    .run     (div_run),
    .sck     (sck_level),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall)
  );

  // Byte reversal turns "byte 0 first, MSB first" into a plain MSB-first shift.
  always_comb begin
    tx_swapped = '0;
    rx_swapped = '0;
    for (int b = 0; b < NBYTES; b++) begin
      tx_swapped[8*b +: 8] = tx_data[WORD_BITS-8-8*b +: 8];
      rx_swapped[8*b +: 8] = rx_shift[WORD_BITS-8-8*b +: 8];
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SETUP;
      ST_SETUP: if (abort) state_next = ST_GAP;
                else if (cnt == CNT_W'(CS_SETUP - 1)) state_next = ST_SHIFT;
      ST_SHIFT: if (abort) state_next = ST_GAP;
                else if (sck_fall && last_bit) state_next = ST_HOLD;
      ST_HOLD:  if (abort || hold_done) state_next = ST_GAP;
      ST_GAP:   if (cnt == CNT_W'(CS_GAP - 1)) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change and rests in IDLE/SHIFT.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (state inside {ST_SETUP, ST_HOLD, ST_GAP}) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      CS       <= 1'b1;
      COPI     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= (state_next == ST_IDLE);
      if (accept) begin
        tx_shift <= tx_swapped;
        COPI     <= tx_swapped[WORD_BITS-1];
        CS       <= 1'b0;
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (abort) begin
        CS   <= 1'b1;
        COPI <= 1'b0;
      end else begin
        if (sck_rise) rx_shift <= {rx_shift[WORD_BITS-2:0], CIPO};
        if (sck_fall) begin
          bit_cnt <= bit_cnt + BIT_W'(1);
          // The last falling edge leaves COPI on the final bit.
          if (!last_bit) begin
            tx_shift <= tx_shift << 1;
            COPI     <= tx_shift[WORD_BITS-2];
          end
        end
        if (state == ST_HOLD && hold_done) begin
          CS       <= 1'b1;
          rx_data  <= rx_swapped;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
